// File: rtl/cpu_clkctl.sv
// cpu_clkctl: run-control scheduler issuing a single-cycle core clock enable
//
// Decides on which clk cycles the CPU core may advance. Four run modes:
// HALT (no enable), STEP (one enable per debounced button press), SLOW
// (enable every slow_div+1 cycles, LED-visible dlclk toggle) and FREE
// (enable every cycle). The core always runs on clk itself.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   mode       in   run mode from switches (00 HALT, 01 STEP, 10 SLOW, 11 FREE), asynchronous
//   step_btn   in   raw bouncing pushbutton, active-high, asynchronous
//   slow_div   in   SLOW period minus 1, sampled only when the divider reloads
//   cpu_en     out  registered core advance enable
//   dlclk      out  toggles on every enable pulse in SLOW/STEP, holds otherwise
//   run_state  out  current run state (HALT=0, STEP=1, SLOW=2, FREE=3)
//   cyc_cnt    out  count of enabled cycles, present only with CPU_CYCLE_COUNT_EN
//
// Optional feature macro: CPU_CYCLE_COUNT_EN adds the 32-bit cyc_cnt output.
module cpu_clkctl #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int DIV_W        = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    input  logic [DIV_W-1:0] slow_div,
    output logic             cpu_en,
    output logic             dlclk,
`ifdef CPU_CYCLE_COUNT_EN
    output logic [31:0]      cyc_cnt,
`endif
    output logic [1:0]       run_state
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [1:0] {HALT = 2'd0, STEP = 2'd1, SLOW = 2'd2, FREE = 2'd3} state_t;

    state_t             state, next_state;
    logic [1:0]         mode_s1, mode_s2;
    logic               btn_s1, btn_s2;
    logic [CNT_W-1:0]   db_cnt;
    logic               db_level, db_prev, db_rise;
    logic [DIV_W-1:0]   div, div_d;
    logic               en_d, dl_d;

    assign run_state = state;
    assign db_rise   = db_level & ~db_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1 <= '0;
            mode_s2 <= '0;
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
        end else begin
            mode_s1 <= mode;
            mode_s2 <= mode_s1;
            btn_s1  <= step_btn;
            btn_s2  <= btn_s1;
        end
    end

    // The counter runs only while the synchronized level disagrees with the
    // accepted one, so any bounce back to the accepted level restarts the wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
        end else begin
            db_prev <= db_level;
            if (btn_s2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                db_level <= btn_s2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HALT;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state_t'(mode_s2);
    end

    // Enable and divider decisions look at the state being entered, so a
    // pulse never survives a departure from SLOW and a press coinciding with
    // STEP entry is honoured.
    always_comb begin
        en_d  = 1'b0;
        div_d = div;
        if (next_state == SLOW) begin
            if (state != SLOW) begin
                div_d = slow_div;
            end else if (div == '0) begin
                en_d  = 1'b1;
                div_d = slow_div;
            end else begin
                div_d = div - 1'b1;
            end
        end else if (next_state == FREE) begin
            en_d = 1'b1;
        end else if (next_state == STEP) begin
            en_d = db_rise;
        end
        dl_d = dlclk ^ (en_d && next_state != FREE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_en <= 1'b0;
            dlclk  <= 1'b0;
            div    <= '0;
        end else begin
            cpu_en <= en_d;
            dlclk  <= dl_d;
            div    <= div_d;
        end
    end

`ifdef CPU_CYCLE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cyc_cnt <= '0;
        else if (cpu_en) cyc_cnt <= cyc_cnt + 1'b1;
    end
`endif
endmodule
